vga_stream: RTL



---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_timing.sv | 65 ++++++
 rtl/vga_stream.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), sync polarity constants and
// the porch/sync total helper used by the raster counters.
package vga_pkg;

   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_BPP      = 3;
   localparam int DEF_PPW      = 16;

   localparam bit SYNC_ACTIVE_LOW  = 1'b0;
   localparam bit SYNC_ACTIVE_HIGH = 1'b1;

   function automatic int timing_total(input int active, input int fp,
                                       input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock divider and raster counters. Exposes the per-pixel tick and
// combinational flags describing the pixel (h,v) the counters point at.
module vga_timing
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int PPW      = DEF_PPW
) (
   input  logic clk,
   input  logic clear,
   output logic tick,
   output logic active,
   output logic word_start,
   output logic origin,
   output logic hs_on,
   output logic vs_on
);

   localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div;
   logic [HW-1:0] h;
   logic [VW-1:0] v;

   // With CLK_DIV=1 the divider never leaves 0, so every cycle ticks.
   assign tick = (div == DW'(CLK_DIV - 1));

   // Divider always runs; the raster position moves only on tick.
   always_ff @(posedge clk) begin
      if (clear) begin
         div <= '0;
         h   <= '0;
         v   <= '0;
      end else begin
         div <= tick ? '0 : div + DW'(1);
         if (tick) begin
            if (h == HW'(H_TOTAL - 1)) begin
               h <= '0;
               v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + VW'(1);
            end else begin
               h <= h + HW'(1);
            end
         end
      end
   end

   assign active     = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
   assign word_start = ((h % HW'(PPW)) == '0);
   assign origin     = (h == '0) && (v == '0);
   assign hs_on      = (h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_on      = (v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_stream.sv
// VGA scan-out engine: single-word prefetch slot fed over valid/ready with
// explicit word/line addressing, pixel shift register and registered pins.
module vga_stream
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = SYNC_ACTIVE_LOW,
   parameter int BPP      = DEF_BPP,
   parameter int PPW      = DEF_PPW,
   localparam int WORDS   = H_ACTIVE / PPW,
   localparam int XW      = (WORDS > 1) ? $clog2(WORDS) : 1,
   localparam int YW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1,
   localparam int WW      = BPP * PPW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic [WW-1:0] word_data,
   input  logic          word_valid,
   output logic          word_ready,
   output logic [XW-1:0] word_x,
   output logic [YW-1:0] line_y,
   output logic          vga_HS,
   output logic          vga_VS,
   output logic [BPP-1:0] vga_rgb,
   output logic          frame_start,
   output logic          underflow
);

   logic clear;
   logic tick, active, word_start, origin, hs_on, vs_on;
   logic run, slot_full, consume, take;
   logic [WW-1:0] slot, shift;
   logic [XW-1:0] ptr_x, next_x;
   logic [YW-1:0] ptr_y, next_y;

   assign clear = rst | ~enable;

   vga_timing #(
      .CLK_DIV (CLK_DIV),
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .PPW     (PPW)
   ) u_timing (
      .clk       (clk),
      .clear     (clear),
      .tick      (tick),
      .active    (active),
      .word_start(word_start),
      .origin    (origin),
      .hs_on     (hs_on),
      .vs_on     (vs_on)
   );

   // run is a registered "out of reset" flag so word_ready stays low for
   // the first cycle after reset/disable is released.
   assign word_ready = run & ~slot_full;
   assign word_x     = ptr_x;
   assign line_y     = ptr_y;

   // Next request address: word-in-line, then line-in-frame wrap.
   always_comb begin
      next_x = ptr_x + XW'(1);
      next_y = ptr_y;
      if (ptr_x == XW'(WORDS - 1)) begin
         next_x = '0;
         next_y = (ptr_y == YW'(V_ACTIVE - 1)) ? '0 : ptr_y + YW'(1);
      end
   end

   // A consume at a word boundary takes priority: a word offered that
   // same cycle is not accepted and the slot stays empty.
   always_comb begin
      consume = tick & active & word_start;
      take    = word_ready & word_valid & ~consume;
   end

   // Prefetch slot, shift register, request pointer and output registers.
   always_ff @(posedge clk) begin
      if (clear) begin
         run         <= 1'b0;
         slot_full   <= 1'b0;
         slot        <= '0;
         shift       <= '0;
         ptr_x       <= '0;
         ptr_y       <= '0;
         vga_HS      <= ~SYNC_POL;
         vga_VS      <= ~SYNC_POL;
         vga_rgb     <= '0;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         run         <= 1'b1;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
         if (tick) begin
            vga_HS      <= hs_on ? SYNC_POL : ~SYNC_POL;
            vga_VS      <= vs_on ? SYNC_POL : ~SYNC_POL;
            frame_start <= origin;
            if (active) begin
               if (word_start) begin
                  if (slot_full) begin
                     vga_rgb   <= slot[BPP-1:0];
                     shift     <= slot >> BPP;
                     slot_full <= 1'b0;
                  end else begin
                     vga_rgb   <= '0;
                     shift     <= '0;
                     underflow <= 1'b1;
                     ptr_x     <= next_x;
                     ptr_y     <= next_y;
                  end
               end else begin
                  vga_rgb <= shift[BPP-1:0];
                  shift   <= shift >> BPP;
               end
            end else begin
               vga_rgb <= '0;
            end
         end
         if (take) begin
            slot      <= word_data;
            slot_full <= 1'b1;
            ptr_x     <= next_x;
            ptr_y     <= next_y;
         end
      end
   end

endmodule
